uart_duplex: RTL and testbench
==============================

# uart_duplex

Full-duplex, parametrised UART: a shared oversampling baud-tick generator feeds a transmitter and a receiver. Both support configurable data width, optional odd/even parity and 1 or 2 stop bits. The TX side takes bytes through a valid/ready handshake. The RX side oversamples the line and reports each received word with parity and framing status. It replaces the TX-only UART top level between the processor/debug logic and the board serial pins.

## Interface
- NB_DATA, 8, data bits per frame (legal 5..9)
- NB_STOP, 1, stop bits per frame (1 or 2)
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
- BAUD_RATE, 9600, line bit rate
- SYS_CLOCK, 100\*(10\*\*6), i_clock frequency in Hz
- OVERSAMPLE, 16, ticks per bit (even, ≥ 8)
- TICK_RATE, SYS_CLOCK/(BAUD_RATE\*OVERSAMPLE), clocks per tick (derived, ≥ 2)
- i_clock  input  1  single system clock; all logic on its rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_tx_data  input  NB_DATA  word to transmit
- i_tx_valid  input  1  i_tx_data is valid
- o_tx_ready  output  1  transmitter can accept a word
- o_tx_data  output  1  serial TX line, idle high
- i_rx_data  input  1  serial RX line (asynchronous to i_clock)
- o_rx_data  output  NB_DATA  last received word
- o_rx_valid  output  1  one-cycle pulse: new word on o_rx_data
- o_rx_parity_err  output  1  parity mismatch on the last word
- o_rx_frame_err  output  1  a stop bit sampled low on the last word

## Operation
- Tick generator:
  - Counter 0..TICK_RATE-1, wraps to 0.
  - Tick pulse is 1 cycle, asserted when counter = TICK_RATE-1.
  - Free-running, shared by TX and RX.
- Frame order: start (0), NB_DATA bits LSB first, parity bit if PARITY_MODE≠0, then NB_STOP stop bits (1).
- Parity rules:
  - Odd: data + parity has an odd number of ones.
  - Even: data + parity has an even number of ones.
- TX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE:
  - o_tx_ready = 1 only in IDLE.
  - Transfer occurs when i_tx_valid & o_tx_ready on a clock edge. The word is latched in that cycle; later changes on i_tx_data are ignored.
  - Each bit holds for exactly OVERSAMPLE ticks.
  - PARITY is skipped when PARITY_MODE = 0.
  - STOP lasts NB_STOP\*OVERSAMPLE ticks.
- RX input sync:
  - i_rx_data passes through a 2-flop synchronizer; both flops reset to 1.
  - All RX logic uses the synchronized value.
- RX FSM, states IDLE → START → DATA → PARITY → STOP → IDLE:
  - IDLE: the synchronized line is seen low → START, tick count cleared.
  - START: after OVERSAMPLE/2 ticks, re-sample. Low → DATA. High → false start, back to IDLE with no output.
  - DATA, PARITY, each STOP bit: sample once every OVERSAMPLE ticks (mid-bit). Data shifts in LSB first.
  - Parity is checked only when PARITY_MODE≠0; otherwise o_rx_parity_err stays 0.
  - Framing error is set if any stop-bit sample is 0.
  - At the last stop-bit sample: update o_rx_data and both error flags, pulse o_rx_valid for 1 cycle, go to IDLE.
  - Outputs hold until the next completed frame.
  - A frame with a framing error is still reported.
- TX and RX are fully independent. Simultaneous TX and RX traffic is legal, including external TX→RX loopback.

## Timing
- Reset values (asynchronous, while i_reset = 0):
  - o_tx_data = 1, o_tx_ready = 1
  - o_rx_data = 0, o_rx_valid = 0, o_rx_parity_err = 0, o_rx_frame_err = 0
  - Tick counter = 0, both FSMs in IDLE
- Reset asserted mid-frame aborts both directions immediately. After release, the line is idle high; no partial word is reported.
- TX timing:
  - The start bit appears on o_tx_data in the cycle after the handshake. o_tx_ready drops in that same cycle.
  - Frame length = (1 + NB_DATA + (PARITY_MODE≠0) + NB_STOP) × OVERSAMPLE ticks.
  - o_tx_ready rises in the cycle after the final stop-bit tick. A back-to-back word may then be accepted in that cycle, so there is no idle bit between frames.
  - i_tx_valid while o_tx_ready = 0 is ignored, with no queuing.
- RX timing:
  - Start-edge detection latency is 2 clocks (synchronizer).
  - o_rx_valid pulses in the cycle after the tick that takes the last stop-bit sample. This falls mid-stop-bit, so a new start edge right after the stop bit is caught.
- TICK_RATE is an integer divide; the resulting baud error is accepted by design.

## Test plan
- Sim parameters: SYS_CLOCK = 9600\*16\*4 (TICK_RATE = 4), NB_DATA = 8, loopback o_tx_data → i_rx_data.
- Basic loopback: send 0xA5, PARITY_MODE=0, NB_STOP=1 → line shows 0,1,0,1,0,0,1,0,1,1 at 64 clocks/bit; o_rx_valid pulses once; o_rx_data = 0xA5; no errors; o_tx_ready low for 640 clocks.
- Parity: PARITY_MODE=1, send 0x01 → parity bit 0. Separately, inject 0x01 with parity 1 directly on i_rx_data → o_rx_parity_err = 1 with o_rx_valid.
- Framing: drive a 0x3C frame with the stop bit forced low → o_rx_data = 0x3C, o_rx_frame_err = 1.
- False start: 20-clock low glitch on i_rx_data → no o_rx_valid, RX returns to IDLE, next valid frame received correctly.
- Back-to-back: hold i_tx_valid with 0x00, 0xFF, 0x55, NB_STOP=2 → three handshakes, no idle gap beyond the 2 stop bits, three correct RX words.
- Reset mid-frame: assert i_reset during TX data bit 3 → o_tx_data = 1 and o_tx_ready = 1 immediately; no o_rx_valid; the next transfer after release is correct.

Source files
------------

// File: rtl/uart_duplex_if.sv
// -----------------------------------------------------------------------------
// uart_duplex_if
//   Parallel-side bundle of the full-duplex UART.
//   TX handshake : i_tx_data / i_tx_valid in, o_tx_ready out.
//   RX report    : o_rx_data, o_rx_valid (1-cycle pulse),
//                  o_rx_parity_err, o_rx_frame_err.
//   Modports: slave  = the UART itself
//             master = the processor/debug logic driving it
//   Signal names are seen from the UART's point of view (i_ = into UART).
// -----------------------------------------------------------------------------
interface uart_duplex_if #(
    parameter int NB_DATA = 8
);
    logic [NB_DATA-1:0] i_tx_data;
    logic               i_tx_valid;
    logic               o_tx_ready;
    logic [NB_DATA-1:0] o_rx_data;
    logic               o_rx_valid;
    logic               o_rx_parity_err;
    logic               o_rx_frame_err;

    modport slave (
        input  i_tx_data,
        input  i_tx_valid,
        output o_tx_ready,
        output o_rx_data,
        output o_rx_valid,
        output o_rx_parity_err,
        output o_rx_frame_err
    );

    modport master (
        output i_tx_data,
        output i_tx_valid,
        input  o_tx_ready,
        input  o_rx_data,
        input  o_rx_valid,
        input  o_rx_parity_err,
        input  o_rx_frame_err
    );
endinterface

// File: rtl/uart_duplex.sv
// -----------------------------------------------------------------------------
// uart_duplex
//   Full-duplex UART: one free-running oversampling tick generator shared by
//   an independent transmitter and receiver. Frame = start(0), NB_DATA bits
//   LSB first, optional odd/even parity, NB_STOP stop bits(1).
//
//   Ports
//     i_clock   : system clock, all logic on rising edge
//     i_reset   : asynchronous, active-low reset
//     bus       : uart_duplex_if.slave (TX handshake + RX report)
//     o_tx_data : serial TX line, idle high
//     i_rx_data : serial RX line, asynchronous to i_clock
// -----------------------------------------------------------------------------
module uart_duplex #(
    parameter int NB_DATA     = 8,
    parameter int NB_STOP     = 1,
    parameter int PARITY_MODE = 0,      // 0 none, 1 odd, 2 even
    parameter int BAUD_RATE   = 9600,
    parameter int SYS_CLOCK   = 100*(10**6),
    parameter int OVERSAMPLE  = 16,
    parameter int TICK_RATE   = SYS_CLOCK/(BAUD_RATE*OVERSAMPLE)
) (
    input  logic         i_clock,
    input  logic         i_reset,
    uart_duplex_if.slave bus,
    output logic         o_tx_data,
    input  logic         i_rx_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam int TW  = (TICK_RATE > 1) ? $clog2(TICK_RATE) : 1;
    // Tick counter inside a bit; wide enough for the whole stop period on TX.
    localparam int TCW = $clog2(NB_STOP*OVERSAMPLE);
    localparam int BW  = $clog2(NB_DATA);

    localparam logic [TCW-1:0] BIT_LAST      = TCW'(OVERSAMPLE-1);
    localparam logic [TCW-1:0] HALF_LAST     = TCW'(OVERSAMPLE/2-1);
    localparam logic [TCW-1:0] STOP_LAST     = TCW'(NB_STOP*OVERSAMPLE-1);
    localparam logic [BW-1:0]  DATA_LAST     = BW'(NB_DATA-1);
    localparam logic [BW-1:0]  STOP_IDX_LAST = BW'(NB_STOP-1);

    // -------------------------------------------------------------------------
    // Tick generator
    // -------------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_q;
    logic          tick;

    assign tick = (tick_cnt_q == TW'(TICK_RATE-1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, exactly like the hardware does.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Transmitter
    // -------------------------------------------------------------------------
    state_e             tx_state_q, tx_state_d;
    logic [NB_DATA-1:0] tx_word_q,  tx_word_d;
    logic [BW-1:0]      tx_bit_q,   tx_bit_d;
    logic [TCW-1:0]     tx_tcnt_q,  tx_tcnt_d;
    logic               tx_line_q,  tx_line_d;
    logic               tx_parity;

    assign tx_parity = (PARITY_MODE == 1) ? ~^tx_word_q : ^tx_word_q;

    // NOTE: every variable gets a default before the case statement so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_word_d  = tx_word_q;
        tx_bit_d   = tx_bit_q;
        tx_tcnt_d  = tx_tcnt_q;

        case (tx_state_q)
            ST_IDLE: begin
                if (bus.i_tx_valid) begin
                    tx_word_d  = bus.i_tx_data;
                    tx_bit_d   = '0;
                    tx_tcnt_d  = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tx_tcnt_q == BIT_LAST) begin
                        tx_tcnt_d  = '0;
                        tx_state_d = ST_DATA;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + TCW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tx_tcnt_q == BIT_LAST) begin
                        tx_tcnt_d = '0;
                        if (tx_bit_q == DATA_LAST) begin
                            tx_state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            tx_bit_d = tx_bit_q + BW'(1);
                        end
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + TCW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (tx_tcnt_q == BIT_LAST) begin
                        tx_tcnt_d  = '0;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + TCW'(1);
                    end
                end
            end
            ST_STOP: begin
                // All stop bits are one continuous high period.
                if (tick) begin
                    if (tx_tcnt_q == STOP_LAST) begin
                        tx_tcnt_d  = '0;
                        tx_state_d = ST_IDLE;
                    end else begin
                        tx_tcnt_d = tx_tcnt_q + TCW'(1);
                    end
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase

        // Line is registered from the next state so it changes together with
        // the state register: the start bit shows up the cycle after handshake.
        case (tx_state_d)
            ST_START:  tx_line_d = 1'b0;
            ST_DATA:   tx_line_d = tx_word_d[tx_bit_d];
            ST_PARITY: tx_line_d = tx_parity;
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tx_state_q <= ST_IDLE;
            tx_word_q  <= '0;
            tx_bit_q   <= '0;
            tx_tcnt_q  <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_word_q  <= tx_word_d;
            tx_bit_q   <= tx_bit_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_line_q  <= tx_line_d;
        end
    end

    assign bus.o_tx_ready = (tx_state_q == ST_IDLE);
    assign o_tx_data      = tx_line_q;

    // -------------------------------------------------------------------------
    // Receiver
    // -------------------------------------------------------------------------
    logic               rx_sync1_q, rx_sync2_q;
    logic               rx_line;
    state_e             rx_state_q, rx_state_d;
    logic [NB_DATA-1:0] rx_shift_q, rx_shift_d;
    logic [BW-1:0]      rx_bit_q,   rx_bit_d;
    logic [TCW-1:0]     rx_tcnt_q,  rx_tcnt_d;
    logic               rx_par_q,   rx_par_d;
    logic               rx_facc_q,  rx_facc_d;   // OR of earlier low stop samples
    logic [NB_DATA-1:0] rx_data_q,  rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_perr_q,  rx_perr_d;
    logic               rx_ferr_q,  rx_ferr_d;
    logic               rx_perr_calc;

    // Synchronizer flops reset to the idle level so reset never fakes a start.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
        end else begin
            rx_sync1_q <= i_rx_data;
            rx_sync2_q <= rx_sync1_q;
        end
    end

    assign rx_line = rx_sync2_q;

    always_comb begin
        rx_perr_calc = 1'b0;
        if (PARITY_MODE == 1) begin
            rx_perr_calc = ~(^{rx_shift_q, rx_par_q});
        end else if (PARITY_MODE == 2) begin
            rx_perr_calc = ^{rx_shift_q, rx_par_q};
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_par_d   = rx_par_q;
        rx_facc_d  = rx_facc_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_valid_d = 1'b0;

        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_line) begin
                    rx_tcnt_d  = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Half a bit later we are mid start bit; every later sample
                // lands mid-bit by counting whole bits from here.
                if (tick) begin
                    if (rx_tcnt_q == HALF_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_line ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (rx_tcnt_q == BIT_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_shift_d = {rx_line, rx_shift_q[NB_DATA-1:1]};
                        if (rx_bit_q == DATA_LAST) begin
                            rx_bit_d   = '0;
                            rx_facc_d  = 1'b0;
                            rx_state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_bit_d = rx_bit_q + BW'(1);
                        end
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    if (rx_tcnt_q == BIT_LAST) begin
                        rx_tcnt_d  = '0;
                        rx_par_d   = rx_line;
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (rx_tcnt_q == BIT_LAST) begin
                        rx_tcnt_d = '0;
                        if (rx_bit_q == STOP_IDX_LAST) begin
                            // Report mid last stop bit so a start edge right
                            // after it is still caught from IDLE.
                            rx_data_d  = rx_shift_q;
                            rx_perr_d  = rx_perr_calc;
                            rx_ferr_d  = rx_facc_q | ~rx_line;
                            rx_valid_d = 1'b1;
                            rx_state_d = ST_IDLE;
                        end else begin
                            rx_facc_d = rx_facc_q | ~rx_line;
                            rx_bit_d  = rx_bit_q + BW'(1);
                        end
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + TCW'(1);
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_state_q <= ST_IDLE;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_tcnt_q  <= '0;
            rx_par_q   <= 1'b0;
            rx_facc_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_par_q   <= rx_par_d;
            rx_facc_q  <= rx_facc_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign bus.o_rx_data       = rx_data_q;
    assign bus.o_rx_valid      = rx_valid_q;
    assign bus.o_rx_parity_err = rx_perr_q;
    assign bus.o_rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_duplex.sv
// -----------------------------------------------------------------------------
// tb_uart_duplex
//   Three UART instances at TICK_RATE = 4 (64 clocks per bit):
//     u_a : no parity, 1 stop  (loopback, or injected RX line)
//     u_b : odd parity, 1 stop (loopback, or injected RX line)
//     u_c : no parity, 2 stop  (loopback, back-to-back traffic)
//   Expected RX words are queued when stimulus is driven and compared by a
//   per-instance monitor whenever o_rx_valid pulses.
// -----------------------------------------------------------------------------
module tb_uart_duplex;

    localparam int SYS    = 9600*16*4;
    localparam int BITCLK = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Bench-side cycle count since reset release; the DUT tick fires on the
    // posedges where this count becomes a multiple of 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    uart_duplex_if #(.NB_DATA(8)) bus_a ();
    uart_duplex_if #(.NB_DATA(8)) bus_b ();
    uart_duplex_if #(.NB_DATA(8)) bus_c ();

    logic tx_a, tx_b, tx_c;
    logic rx_a, rx_b, rx_c;
    logic inj_line, inj_a, inj_b;

    assign rx_a = inj_a ? inj_line : tx_a;
    assign rx_b = inj_b ? inj_line : tx_b;
    assign rx_c = tx_c;

    uart_duplex #(.NB_DATA(8), .NB_STOP(1), .PARITY_MODE(0), .BAUD_RATE(9600),
                  .SYS_CLOCK(SYS), .OVERSAMPLE(16))
        u_a (.i_clock(clk), .i_reset(rst_n), .bus(bus_a), .o_tx_data(tx_a), .i_rx_data(rx_a));
    uart_duplex #(.NB_DATA(8), .NB_STOP(1), .PARITY_MODE(1), .BAUD_RATE(9600),
                  .SYS_CLOCK(SYS), .OVERSAMPLE(16))
        u_b (.i_clock(clk), .i_reset(rst_n), .bus(bus_b), .o_tx_data(tx_b), .i_rx_data(rx_b));
    uart_duplex #(.NB_DATA(8), .NB_STOP(2), .PARITY_MODE(0), .BAUD_RATE(9600),
                  .SYS_CLOCK(SYS), .OVERSAMPLE(16))
        u_c (.i_clock(clk), .i_reset(rst_n), .bus(bus_c), .o_tx_data(tx_c), .i_rx_data(rx_c));

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t mon_a, mon_b, mon_c;
    int   nvalid_a = 0, nvalid_b = 0, nvalid_c = 0;

    // ---------------------------------------------------------------- monitors
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_a.o_rx_valid === 1'b1) begin
            nvalid_a++;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rx_a_unexpected: got data=%h perr=%b ferr=%b, required no word",
                         bus_a.o_rx_data, bus_a.o_rx_parity_err, bus_a.o_rx_frame_err);
            end else begin
                mon_a = q_a.pop_front();
                if ({bus_a.o_rx_data, bus_a.o_rx_parity_err, bus_a.o_rx_frame_err} !== mon_a) begin
                    errors++;
                    $display("FAIL rx_a_word: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                             bus_a.o_rx_data, bus_a.o_rx_parity_err, bus_a.o_rx_frame_err,
                             mon_a.data, mon_a.perr, mon_a.ferr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_b.o_rx_valid === 1'b1) begin
            nvalid_b++;
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL rx_b_unexpected: got data=%h perr=%b ferr=%b, required no word",
                         bus_b.o_rx_data, bus_b.o_rx_parity_err, bus_b.o_rx_frame_err);
            end else begin
                mon_b = q_b.pop_front();
                if ({bus_b.o_rx_data, bus_b.o_rx_parity_err, bus_b.o_rx_frame_err} !== mon_b) begin
                    errors++;
                    $display("FAIL rx_b_word: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                             bus_b.o_rx_data, bus_b.o_rx_parity_err, bus_b.o_rx_frame_err,
                             mon_b.data, mon_b.perr, mon_b.ferr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_c.o_rx_valid === 1'b1) begin
            nvalid_c++;
            checks++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL rx_c_unexpected: got data=%h perr=%b ferr=%b, required no word",
                         bus_c.o_rx_data, bus_c.o_rx_parity_err, bus_c.o_rx_frame_err);
            end else begin
                mon_c = q_c.pop_front();
                if ({bus_c.o_rx_data, bus_c.o_rx_parity_err, bus_c.o_rx_frame_err} !== mon_c) begin
                    errors++;
                    $display("FAIL rx_c_word: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                             bus_c.o_rx_data, bus_c.o_rx_parity_err, bus_c.o_rx_frame_err,
                             mon_c.data, mon_c.perr, mon_c.ferr);
                end
            end
        end
    end

    // ----------------------------------------------------------------- helpers
    function automatic int qsize(input int which);
        case (which)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic set_tx(input int which, input logic v, input logic [7:0] d);
        case (which)
            0:       begin bus_a.i_tx_valid = v; bus_a.i_tx_data = d; end
            1:       begin bus_b.i_tx_valid = v; bus_b.i_tx_data = d; end
            default: begin bus_c.i_tx_valid = v; bus_c.i_tx_data = d; end
        endcase
    endtask

    // Ends on the negedge just before a tick posedge, so a handshake driven
    // now is tick-aligned and every bit lasts exactly 64 clocks.
    task automatic align_tick();
        do @(negedge clk); while (cyc % 4 != 3);
    endtask

    task automatic wait_drain(input int which, input int limit);
        int n = 0;
        while (qsize(which) != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (qsize(which) != 0) begin
            errors++;
            $display("FAIL rx_timeout_%0d: %0d words pending after %0d clocks, required 0",
                     which, qsize(which), limit);
        end
    endtask

    // Drives bits[0..n-1] on the injected line, 64 clocks each except the last.
    task automatic inject_frame(input logic [15:0] bits, input int n, input int last_len);
        for (int i = 0; i < n; i++) begin
            inj_line = bits[i];
            repeat ((i == n - 1) ? last_len : BITCLK) @(negedge clk);
        end
        inj_line = 1'b1;
        repeat (BITCLK) @(negedge clk);
    endtask

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_a, bus_a.o_tx_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_tx_a: tx=%b ready=%b, required tx=1 ready=1", tx_a, bus_a.o_tx_ready);
        end
        checks++;
        if ({bus_a.o_rx_data, bus_a.o_rx_valid, bus_a.o_rx_parity_err, bus_a.o_rx_frame_err} !== 11'h000) begin
            errors++;
            $display("FAIL reset_rx_a: data=%h valid=%b perr=%b ferr=%b, required all 0",
                     bus_a.o_rx_data, bus_a.o_rx_valid, bus_a.o_rx_parity_err, bus_a.o_rx_frame_err);
        end
        checks++;
        if ({tx_b, bus_b.o_tx_ready, tx_c, bus_c.o_tx_ready} !== 4'hF) begin
            errors++;
            $display("FAIL reset_tx_bc: tx_b=%b rdy_b=%b tx_c=%b rdy_c=%b, required all 1",
                     tx_b, bus_b.o_tx_ready, tx_c, bus_c.o_tx_ready);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_basic_loopback();
        logic [15:0] exp_bits = {6'h3F, 8'hA5, 1'b0} ; // stop, data LSB first, start
        int  start = nvalid_a;
        int  low   = 0;
        bit  seen  = 0;
        q_a.push_back('{8'hA5, 1'b0, 1'b0});
        align_tick();
        set_tx(0, 1'b1, 8'hA5);
        @(negedge clk);
        set_tx(0, 1'b0, 8'h00);    // later changes must be ignored
        for (int k = 0; k < 720; k++) begin
            if (k > 0) @(negedge clk);
            if (!seen) begin
                if (bus_a.o_tx_ready === 1'b0) low++;
                else seen = 1;
            end
            if ((k % BITCLK == BITCLK/2 && k / BITCLK < 10) || k == 63 || k == 64) begin
                checks++;
                if (tx_a !== exp_bits[k / BITCLK]) begin
                    errors++;
                    $display("FAIL basic_line: clock %0d line=%b, required %b", k, tx_a, exp_bits[k / BITCLK]);
                end
            end
        end
        checks++;
        if (low != 640) begin
            errors++;
            $display("FAIL basic_ready_low: %0d clocks, required 640", low);
        end
        wait_drain(0, 200);
        checks++;
        if (nvalid_a - start != 1) begin
            errors++;
            $display("FAIL basic_valid_count: %0d pulses, required 1", nvalid_a - start);
        end
        checks++;
        if (bus_a.o_rx_data !== 8'hA5 || bus_a.o_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: data=%h valid=%b, required data=a5 valid=0",
                     bus_a.o_rx_data, bus_a.o_rx_valid);
        end
    endtask

    task automatic test_parity();
        int n = 0;
        q_b.push_back('{8'h01, 1'b0, 1'b0});
        align_tick();
        set_tx(1, 1'b1, 8'h01);
        @(negedge clk);
        set_tx(1, 1'b0, 8'h00);
        repeat (BITCLK + BITCLK/2) @(negedge clk);          // mid data bit 0
        checks++;
        if (tx_b !== 1'b1) begin
            errors++;
            $display("FAIL parity_d0: line=%b, required 1", tx_b);
        end
        repeat (8*BITCLK) @(negedge clk);                   // mid parity bit
        checks++;
        if (tx_b !== 1'b0) begin
            errors++;
            $display("FAIL parity_bit_odd_01: line=%b, required 0", tx_b);
        end
        wait_drain(1, 200);
        while (bus_b.o_tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        // 0x01 with parity 1 has an even count of ones: odd-parity error.
        inj_line = 1'b1;
        inj_b    = 1'b1;
        repeat (BITCLK) @(negedge clk);
        q_b.push_back('{8'h01, 1'b1, 1'b0});
        inject_frame({5'h1F, 1'b1, 1'b1, 8'h01, 1'b0}, 11, BITCLK);
        wait_drain(1, 200);
        checks++;
        if (bus_b.o_rx_parity_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_err_hold: perr=%b, required 1", bus_b.o_rx_parity_err);
        end
        inj_b = 1'b0;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic test_framing();
        int start = nvalid_a;
        inj_line = 1'b1;
        inj_a    = 1'b1;
        repeat (BITCLK) @(negedge clk);
        q_a.push_back('{8'h3C, 1'b0, 1'b1});
        // Stop bit held low only past its mid sample, then released.
        inject_frame({6'h00, 1'b0, 8'h3C, 1'b0}, 10, 44);
        wait_drain(0, 200);
        repeat (2*BITCLK) @(negedge clk);
        checks++;
        if (nvalid_a - start != 1 || bus_a.o_rx_frame_err !== 1'b1) begin
            errors++;
            $display("FAIL framing: pulses=%0d ferr=%b, required pulses=1 ferr=1",
                     nvalid_a - start, bus_a.o_rx_frame_err);
        end
    endtask

    task automatic test_false_start();
        int start = nvalid_a;
        inj_line = 1'b0;
        repeat (20) @(negedge clk);
        inj_line = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (nvalid_a != start) begin
            errors++;
            $display("FAIL false_start: %0d pulses, required 0", nvalid_a - start);
        end
        q_a.push_back('{8'h96, 1'b0, 1'b0});
        inject_frame({6'h3F, 8'h96, 1'b0}, 10, BITCLK);
        wait_drain(0, 200);
        inj_a = 1'b0;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h55};
        int hs [3];
        int exp_hs;
        int n;
        for (int k = 0; k < 3; k++) q_c.push_back('{words[k], 1'b0, 1'b0});
        align_tick();
        for (int k = 0; k < 3; k++) begin
            set_tx(2, 1'b1, words[k]);
            n = 0;
            while (bus_c.o_tx_ready !== 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            hs[k] = cyc + 1;       // posedge on which the handshake happens
            @(negedge clk);
        end
        set_tx(2, 1'b0, 8'h00);
        for (int k = 1; k < 3; k++) begin
            // 176 ticks per frame; ready rises the clock after the last one.
            exp_hs = (hs[k-1] / 4 + 1) * 4 + 175 * 4 + 1;
            checks++;
            if (hs[k] != exp_hs) begin
                errors++;
                $display("FAIL b2b_handshake_%0d: at clock %0d, required %0d", k, hs[k], exp_hs);
            end
        end
        wait_drain(2, 1500);
    endtask

    task automatic test_reset_mid_frame();
        int start = nvalid_a;
        align_tick();
        set_tx(0, 1'b1, 8'hF0);
        @(negedge clk);
        set_tx(0, 1'b0, 8'h00);
        repeat (4*BITCLK + BITCLK/2 - 1) @(negedge clk);   // mid data bit 3
        checks++;
        if (tx_a !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_bit3: line=%b, required 0", tx_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_a, bus_a.o_tx_ready, bus_a.o_rx_valid} !== 3'b110) begin
            errors++;
            $display("FAIL rstmid_async: tx=%b ready=%b valid=%b, required 1 1 0",
                     tx_a, bus_a.o_tx_ready, bus_a.o_rx_valid);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (900) @(negedge clk);
        checks++;
        if (nvalid_a != start) begin
            errors++;
            $display("FAIL rstmid_partial: %0d pulses, required 0", nvalid_a - start);
        end
        q_a.push_back('{8'h3A, 1'b0, 1'b0});
        align_tick();
        set_tx(0, 1'b1, 8'h3A);
        @(negedge clk);
        set_tx(0, 1'b0, 8'h00);
        wait_drain(0, 1500);
        checks++;
        if (nvalid_a - start != 1) begin
            errors++;
            $display("FAIL rstmid_next: %0d pulses, required 1", nvalid_a - start);
        end
    endtask

    initial begin
        inj_line = 1'b1;
        inj_a    = 1'b0;
        inj_b    = 1'b0;
        set_tx(0, 1'b0, 8'h00);
        set_tx(1, 1'b0, 8'h00);
        set_tx(2, 1'b0, 8'h00);
        test_reset();
        test_basic_loopback();
        test_parity();
        test_framing();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (200) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
